alu_4_bit: RTL and testbench
============================

ALU_4_BIT -- requirements
Module: alu_4_bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: WIDTH, 4, operand/result width; only 4 is supported and other values SHALL fail elaboration.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operands and opcode are sampled on this clk edge.
REQ-006 A  input  4  operand A, unsigned.
REQ-007 B  input  4  operand B, unsigned.
REQ-008 ALU_Sel  input  4  opcode.
REQ-009 out_valid  output  1  Result and the flags hold a new value this cycle.
REQ-010 Result  output  4  registered result.
REQ-011 Carry  output  1  registered carry/borrow/shift-out.
REQ-012 Zero  output  1  registered zero flag.
REQ-013 Greater  output  1  registered unsigned A>B flag.

Function
REQ-014 Opcode to Result mapping, all modulo 16:
- 0: A+B
- 1: A-B
- 2: A&B
- 3: A|B
- 4: A^B
- 5: ~A
- 6: A<<1
- 7: A>>1 (logical)
- 8: A+1
- 9: A-1
- A: A
- B: B
- C: ~(A&B)
- D: ~(A|B)
- E: ~(A^B)
- F: compare, Result=0.
REQ-015 Carry:
- ADD: bit 4 of A+B.
- SUB: 1 when A<B (borrow).
- INC: 1 when A=F.
- DEC: 1 when A=0.
- SHL: A[3].
- SHR: A[0].
- All other opcodes: 0.
REQ-016 Zero SHALL be (Result==0) for opcodes 0-E and (A==B) for opcode F.
REQ-017 Greater SHALL be unsigned (A>B) for every opcode.
REQ-018 Latency SHALL be one cycle: in_valid=1 at edge N gives out_valid=1 with the matching Result and flags after edge N.
REQ-019 When in_valid=0, Result and the flags SHALL hold their previous values and out_valid SHALL be 0 after the edge.
REQ-020 Back-to-back in_valid SHALL produce one result per cycle, with no stalls and no backpressure.
REQ-021 Outputs SHALL never be X or Z after the first reset, for any value of A, B or ALU_Sel.

Reset
REQ-022 While rst=1 at a clk edge, Result, Carry, Zero, Greater and out_valid SHALL all become 0.
REQ-023 rst SHALL take priority over a simultaneous in_valid; the input sampled in that cycle is discarded.
REQ-024 Reset asserted mid-stream SHALL discard any result not yet presented; the first valid input after rst deasserts is processed normally.

Configuration
REQ-025 When macro ALU_4_BIT_OVERFLOW_EN is defined, the block SHALL add an output Overflow (output, 1 bit, registered, reset 0) that gives signed two's-complement overflow for ADD, SUB, INC and DEC, and 0 for all other opcodes.
REQ-026 When ALU_4_BIT_OVERFLOW_EN is not defined, the Overflow port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package alu_4_bit_pkg SHALL hold:
- the opcode enum alu_op_e (ADD, SUB, AND, OR, XOR, NOTA, SHL, SHR, INC, DEC, PASSA, PASSB, NAND, NOR, XNOR, CMP);
- the WIDTH constant;
- a flags struct.
REQ-028 Combinational datapath sub-module alu_4_bit_comb SHALL compute the result and flags.
REQ-029 The alu_4_bit top SHALL hold only the registers and valid logic.

Verification
REQ-030 ADD/SUB: A=3, B=1:
- ADD -> Result=4, Carry=0, Zero=0, Greater=1.
- SUB -> Result=2, Carry=0.
- SUB with A=1, B=3 -> Result=E, Carry=1, Greater=0.
REQ-031 Shifts:
- SHL, A=3 -> Result=6, Carry=0.
- SHL, A=9 -> Result=2, Carry=1.
- SHR, A=9 -> Result=4, Carry=1.
REQ-032 INC/DEC wrap:
- INC, A=F -> Result=0, Carry=1, Zero=1.
- DEC, A=0 -> Result=F, Carry=1.
REQ-033 Compare:
- CMP, A=5, B=5 -> Result=0, Zero=1, Greater=0.
- CMP, A=6, B=5 -> Zero=0, Greater=1.
REQ-034 Reset and hold:
- rst=1 together with in_valid=1 (ADD, A=F, B=F) -> all outputs 0 after the edge.
- in_valid=0 on the next edge -> outputs hold and out_valid=0.
REQ-035 Random regression: 500 random in_valid=1 cycles (A, B, ALU_Sel), each checked one cycle later against the REQ-014..017 model.
REQ-036 Overflow, with ALU_4_BIT_OVERFLOW_EN defined:
- ADD, A=7, B=1 -> Overflow=1.
- SUB, A=8, B=1 -> Overflow=1.

Source files
------------

// File: rtl/alu_4_bit_pkg.sv
// Shared types and constants for the 4-bit ALU.
// Optional feature macro: ALU_4_BIT_OVERFLOW_EN (adds the signed Overflow flag).
package alu_4_bit_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [3:0] {
    ADD   = 4'h0,
    SUB   = 4'h1,
    AND   = 4'h2,
    OR    = 4'h3,
    XOR   = 4'h4,
    NOTA  = 4'h5,
    SHL   = 4'h6,
    SHR   = 4'h7,
    INC   = 4'h8,
    DEC   = 4'h9,
    PASSA = 4'hA,
    PASSB = 4'hB,
    NAND  = 4'hC,
    NOR   = 4'hD,
    XNOR  = 4'hE,
    CMP   = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic greater;
`ifdef ALU_4_BIT_OVERFLOW_EN
    logic overflow;
`endif
  } alu_flags_t;

endpackage

// File: rtl/alu_4_bit_comb.sv
// Combinational datapath of the 4-bit ALU: result and flags from operands/opcode.
// Optional feature macro: ALU_4_BIT_OVERFLOW_EN (signed overflow for ADD/SUB/INC/DEC).
module alu_4_bit_comb
  import alu_4_bit_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  alu_op_e              op,
  output logic [ALU_WIDTH-1:0] result,
  output alu_flags_t           flags
);

  logic [ALU_WIDTH:0] sum_s;
  logic [ALU_WIDTH:0] diff_s;

  // Extended add/subtract so bit 4 carries the carry-out or the borrow.
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Opcode decode: result plus carry/borrow/shift-out; zero and greater follow.
  always_comb begin
    result        = 4'h0;
    flags         = '0;
    case (op)
      ADD:   begin result = sum_s[3:0];  flags.carry = sum_s[4];       end
      SUB:   begin result = diff_s[3:0]; flags.carry = diff_s[4];      end
      AND:   result = a & b;
      OR:    result = a | b;
      XOR:   result = a ^ b;
      NOTA:  result = ~a;
      SHL:   begin result = {a[2:0], 1'b0}; flags.carry = a[3];       end
      SHR:   begin result = {1'b0, a[3:1]}; flags.carry = a[0];       end
      INC:   begin result = a + 4'h1; flags.carry = (a == 4'hF);      end
      DEC:   begin result = a - 4'h1; flags.carry = (a == 4'h0);      end
      PASSA: result = a;
      PASSB: result = b;
      NAND:  result = ~(a & b);
      NOR:   result = ~(a | b);
      XNOR:  result = ~(a ^ b);
      CMP:   result = 4'h0;
      default: result = 4'h0;
    endcase

    if (op == CMP) begin
      flags.zero = (a == b);
    end else begin
      flags.zero = (result == 4'h0);
    end
    flags.greater = (a > b);

`ifdef ALU_4_BIT_OVERFLOW_EN
    // Signed overflow: result sign disagrees with what the operand signs imply.
    case (op)
      ADD:     flags.overflow = (a[3] == b[3]) && (result[3] != a[3]);
      SUB:     flags.overflow = (a[3] != b[3]) && (result[3] != a[3]);
      INC:     flags.overflow = (a == 4'h7);
      DEC:     flags.overflow = (a == 4'h8);
      default: flags.overflow = 1'b0;
    endcase
`endif
  end

endmodule

// File: rtl/alu_4_bit.sv
// 4-bit ALU top: one-cycle registered result/flags with a valid strobe.
// Optional feature macro: ALU_4_BIT_OVERFLOW_EN (adds registered Overflow output).
module alu_4_bit
  import alu_4_bit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             Greater
`ifdef ALU_4_BIT_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  if (WIDTH != ALU_WIDTH) begin : g_width_check
    $error("alu_4_bit supports only WIDTH=4");
  end

  logic [ALU_WIDTH-1:0] res_s;
  alu_flags_t           flags_s;

  alu_4_bit_comb u_comb (
    .a      (A),
    .b      (B),
    .op     (alu_op_e'(ALU_Sel)),
    .result (res_s),
    .flags  (flags_s)
  );

  // Output registers: reset clears, a valid input loads, otherwise hold with out_valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= 4'h0;
      Carry     <= 1'b0;
      Zero      <= 1'b0;
      Greater   <= 1'b0;
`ifdef ALU_4_BIT_OVERFLOW_EN
      Overflow  <= 1'b0;
`endif
    end else if (in_valid) begin
      out_valid <= 1'b1;
      Result    <= res_s;
      Carry     <= flags_s.carry;
      Zero      <= flags_s.zero;
      Greater   <= flags_s.greater;
`ifdef ALU_4_BIT_OVERFLOW_EN
      Overflow  <= flags_s.overflow;
`endif
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_4_bit.sv
// Directed and random self-checking bench for alu_4_bit.
// Optional feature macro: ALU_4_BIT_OVERFLOW_EN (also checks Overflow).
module tb_alu_4_bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] ALU_Sel;
  logic       out_valid;
  logic [3:0] Result;
  logic       Carry;
  logic       Zero;
  logic       Greater;
`ifdef ALU_4_BIT_OVERFLOW_EN
  logic       Overflow;
`endif

  int total;
  int bad;

  alu_4_bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .Result    (Result),
    .Carry     (Carry),
    .Zero      (Zero),
    .Greater   (Greater)
`ifdef ALU_4_BIT_OVERFLOW_EN
    ,
    .Overflow  (Overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic v, input logic r, input logic [3:0] op,
                      input logic [3:0] a, input logic [3:0] b);
    in_valid = v; rst = r; ALU_Sel = op; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model in integer arithmetic: returns {ovf, result[3:0], carry, zero, greater}.
  function automatic logic [7:0] model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, sa, sb, r, c, ov, s;
    logic z, g;
    logic [3:0] r4;
    ia = int'(a); ib = int'(b);
    sa = (ia >= 8) ? ia - 16 : ia;
    sb = (ib >= 8) ? ib - 16 : ib;
    r = 0; c = 0; ov = 0; s = 0;
    case (op)
      4'h0: begin r = ia + ib; c = (r > 15) ? 1 : 0; s = sa + sb; ov = (s > 7 || s < -8) ? 1 : 0; end
      4'h1: begin r = ia - ib; c = (ia < ib) ? 1 : 0; s = sa - sb; ov = (s > 7 || s < -8) ? 1 : 0; end
      4'h2: r = ia & ib;
      4'h3: r = ia | ib;
      4'h4: r = ia ^ ib;
      4'h5: r = 15 - ia;
      4'h6: begin r = ia * 2; c = (ia >= 8) ? 1 : 0; end
      4'h7: begin r = ia / 2; c = ia % 2; end
      4'h8: begin r = ia + 1; c = (ia == 15) ? 1 : 0; ov = (sa + 1 > 7) ? 1 : 0; end
      4'h9: begin r = ia - 1; c = (ia == 0) ? 1 : 0; ov = (sa - 1 < -8) ? 1 : 0; end
      4'hA: r = ia;
      4'hB: r = ib;
      4'hC: r = 15 - (ia & ib);
      4'hD: r = 15 - (ia | ib);
      4'hE: r = 15 - (ia ^ ib);
      default: r = 0;
    endcase
    r  = r & 15;
    r4 = r[3:0];
    z  = (op == 4'hF) ? (ia == ib) : (r == 0);
    g  = (ia > ib);
    return {ov[0], r4, c[0], z, g};
  endfunction

  initial begin
    logic [3:0] ra, rb, rop;
    logic [7:0] m;
    clk = 1'b0; total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; A = 4'h0; B = 4'h0; ALU_Sel = 4'h0;

    // Reset with a simultaneous valid ADD F+F: everything must be 0.
    step(1'b1, 1'b1, 4'h0, 4'hF, 4'hF);
    step(1'b1, 1'b1, 4'h0, 4'hF, 4'hF);
    check("rst_all", {out_valid, Result, Carry, Zero, Greater}, 8'h00);
`ifdef ALU_4_BIT_OVERFLOW_EN
    check("rst_ovf", {7'd0, Overflow}, 8'd0);
`endif
    step(1'b0, 1'b0, 4'h0, 4'h7, 4'h1);
    check("idle_after_rst", {out_valid, Result, Carry, Zero, Greater}, 8'h00);

    // ADD / SUB
    step(1'b1, 1'b0, 4'h0, 4'h3, 4'h1);
    check("add_3_1", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h4, 1'b0, 1'b0, 1'b1});
    step(1'b0, 1'b0, 4'h1, 4'h0, 4'h5);
    check("hold", {out_valid, Result, Carry, Zero, Greater}, {1'b0, 4'h4, 1'b0, 1'b0, 1'b1});
    step(1'b1, 1'b0, 4'h1, 4'h3, 4'h1);
    check("sub_3_1", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h2, 1'b0, 1'b0, 1'b1});
    step(1'b1, 1'b0, 4'h1, 4'h1, 4'h3);
    check("sub_1_3", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'hE, 1'b1, 1'b0, 1'b0});

    // Shifts
    step(1'b1, 1'b0, 4'h6, 4'h3, 4'h0);
    check("shl_3", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h6, 1'b0, 1'b0, 1'b1});
    step(1'b1, 1'b0, 4'h6, 4'h9, 4'h0);
    check("shl_9", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h2, 1'b1, 1'b0, 1'b1});
    step(1'b1, 1'b0, 4'h7, 4'h9, 4'h0);
    check("shr_9", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h4, 1'b1, 1'b0, 1'b1});

    // INC / DEC wrap
    step(1'b1, 1'b0, 4'h8, 4'hF, 4'h0);
    check("inc_f", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h0, 1'b1, 1'b1, 1'b1});
    step(1'b1, 1'b0, 4'h9, 4'h0, 4'h0);
    check("dec_0", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'hF, 1'b1, 1'b0, 1'b0});

    // Compare
    step(1'b1, 1'b0, 4'hF, 4'h5, 4'h5);
    check("cmp_5_5", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h0, 1'b0, 1'b1, 1'b0});
    step(1'b1, 1'b0, 4'hF, 4'h6, 4'h5);
    check("cmp_6_5", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h0, 1'b0, 1'b0, 1'b1});

    // Logic ops spot check
    step(1'b1, 1'b0, 4'hC, 4'hC, 4'hA);
    check("nand_c_a", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h7, 1'b0, 1'b0, 1'b1});

    // Mid-stream reset discards the in-flight input; next valid is processed.
    step(1'b1, 1'b1, 4'h0, 4'h2, 4'h2);
    check("midrst", {out_valid, Result, Carry, Zero, Greater}, 8'h00);
    step(1'b1, 1'b0, 4'h0, 4'h2, 4'h2);
    check("after_midrst", {out_valid, Result, Carry, Zero, Greater}, {1'b1, 4'h4, 1'b0, 1'b0, 1'b0});

`ifdef ALU_4_BIT_OVERFLOW_EN
    step(1'b1, 1'b0, 4'h0, 4'h7, 4'h1);
    check("ovf_add_7_1", {7'd0, Overflow}, 8'd1);
    step(1'b1, 1'b0, 4'h1, 4'h8, 4'h1);
    check("ovf_sub_8_1", {7'd0, Overflow}, 8'd1);
    step(1'b1, 1'b0, 4'h0, 4'h3, 4'h1);
    check("ovf_add_3_1", {7'd0, Overflow}, 8'd0);
`endif

    // Random back-to-back regression against the integer model.
    for (int i = 0; i < 500; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 4'($urandom_range(0, 15));
      step(1'b1, 1'b0, rop, ra, rb);
      m = model(rop, ra, rb);
      check($sformatf("rand%0d_op%h_a%h_b%h", i, rop, ra, rb),
            {out_valid, Result, Carry, Zero, Greater}, {1'b1, m[6:0]});
`ifdef ALU_4_BIT_OVERFLOW_EN
      check($sformatf("rand%0d_ovf", i), {7'd0, Overflow}, {7'd0, m[7]});
`endif
    end

    step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    check("final_idle_valid", {7'd0, out_valid}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
